// File: rtl/seleccion_cartas.sv
// Turn controller for the 16-card memory game: cursor, two picks, show delay, verifier handshake.
// Latency: verif_start rises SHOW_CYCLES cycles after the second pick; the board is absorbed on the verif_done edge.
// Backpressure: VERIFY holds the board until verif_done. Optional TURN_TIMEOUT_EN adds a per-pick idle timeout.
module seleccion_cartas #(
    parameter int N_CARDS        = 16,
    parameter int SHOW_CYCLES    = 50000000,
    parameter int TIMEOUT_CYCLES = 500000000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load,
    input  logic [N_CARDS-1:0][4:0]  arr_cards_in,
    input  logic                     turn_en,
    input  logic                     btn_next,
    input  logic                     btn_prev,
    input  logic                     btn_sel,
    input  logic                     verif_done,
    input  logic                     verif_pareja,
    input  logic [N_CARDS-1:0][4:0]  arr_verif_in,
    output logic [N_CARDS-1:0][4:0]  arr_cards_out,
    output logic [3:0]               cursor,
    output logic                     verif_start,
    output logic                     turn_done,
    output logic                     turn_match,
    output logic                     board_complete,
    output logic                     turn_timeout
);

    if (N_CARDS != 16 || SHOW_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("seleccion_cartas: unsupported parameter values");
    end

    typedef enum logic [2:0] {IDLE, PICK1, PICK2, SHOW, VERIFY} state_t;

    localparam logic [31:0] SHOW_LAST = 32'(SHOW_CYCLES - 1);

    state_t                   state_q;
    logic [N_CARDS-1:0][4:0]  board_q;
    logic [3:0]               cursor_q, cursor_d, pos1_q;
    logic [31:0]              show_cnt_q;
    logic                     verif_start_q, turn_done_q, turn_match_q, board_complete_q;
    logic                     sel_ok, all_matched;

    always_comb begin
        cursor_d = cursor_q;
        if (btn_next && !btn_prev)      cursor_d = cursor_q + 4'd1;
        else if (btn_prev && !btn_next) cursor_d = cursor_q - 4'd1;
    end

    assign sel_ok = btn_sel && (board_q[cursor_q][1:0] == 2'b00);

    always_comb begin
        all_matched = 1'b1;
        for (int i = 0; i < N_CARDS; i++) begin
            if (arr_verif_in[i][1:0] != 2'b10) all_matched = 1'b0;
        end
    end

`ifdef TURN_TIMEOUT_EN
    localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);
    logic [31:0] to_cnt_q;
    logic        turn_timeout_q;
    logic        any_btn;
    assign any_btn      = btn_next | btn_prev | btn_sel;
    assign turn_timeout = turn_timeout_q;
`else
    assign turn_timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= IDLE;
            for (int i = 0; i < N_CARDS; i++) board_q[i] <= 5'b00011;
            cursor_q         <= 4'd0;
            pos1_q           <= 4'd0;
            show_cnt_q       <= 32'd0;
            verif_start_q    <= 1'b0;
            turn_done_q      <= 1'b0;
            turn_match_q     <= 1'b0;
            board_complete_q <= 1'b0;
`ifdef TURN_TIMEOUT_EN
            to_cnt_q         <= 32'd0;
            turn_timeout_q   <= 1'b0;
`endif
        end else begin
            verif_start_q <= 1'b0;
            turn_done_q   <= 1'b0;
`ifdef TURN_TIMEOUT_EN
            turn_timeout_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (load) begin
                        board_q          <= arr_cards_in;
                        cursor_q         <= 4'd0;
                        board_complete_q <= 1'b0;
                    end else if (turn_en && !board_complete_q) begin
                        state_q <= PICK1;
                    end
                end
                PICK1: begin
                    // Select acts on the pre-move cursor; a simultaneous move still applies.
                    cursor_q <= cursor_d;
                    if (sel_ok) begin
                        board_q[cursor_q][1:0] <= 2'b01;
                        pos1_q                 <= cursor_q;
                        state_q                <= PICK2;
                    end
                end
                PICK2: begin
                    cursor_q <= cursor_d;
                    if (sel_ok && cursor_q != pos1_q) begin
                        board_q[cursor_q][1:0] <= 2'b01;
                        show_cnt_q             <= 32'd0;
                        state_q                <= SHOW;
                    end
                end
                SHOW: begin
                    if (show_cnt_q == SHOW_LAST) begin
                        state_q       <= VERIFY;
                        verif_start_q <= 1'b1;
                    end else begin
                        show_cnt_q <= show_cnt_q + 32'd1;
                    end
                end
                VERIFY: begin
                    if (verif_done) begin
                        board_q          <= arr_verif_in;
                        turn_match_q     <= verif_pareja;
                        turn_done_q      <= 1'b1;
                        board_complete_q <= all_matched;
                        state_q          <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
`ifdef TURN_TIMEOUT_EN
            // Idle counter restarts on any button and on every pick-state entry.
            if (state_q == PICK1 || state_q == PICK2) begin
                if (any_btn) begin
                    to_cnt_q <= 32'd0;
                end else if (to_cnt_q == TO_LAST) begin
                    to_cnt_q       <= 32'd0;
                    turn_timeout_q <= 1'b1;
                    turn_done_q    <= 1'b1;
                    turn_match_q   <= 1'b0;
                    state_q        <= IDLE;
                    if (state_q == PICK2) board_q[pos1_q][1:0] <= 2'b00;
                end else begin
                    to_cnt_q <= to_cnt_q + 32'd1;
                end
            end else begin
                to_cnt_q <= 32'd0;
            end
`endif
        end
    end

    assign arr_cards_out  = board_q;
    assign cursor         = cursor_q;
    assign verif_start    = verif_start_q;
    assign turn_done      = turn_done_q;
    assign turn_match     = turn_match_q;
    assign board_complete = board_complete_q;

endmodule

// File: tb/tb_seleccion_cartas.sv
// Directed bench for seleccion_cartas with SHOW_CYCLES=4 and TIMEOUT_CYCLES=8.
module tb_seleccion_cartas;
    localparam int SHOW = 4;
    localparam int TO   = 8;
`ifdef TURN_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst, load, turn_en, btn_next, btn_prev, btn_sel, verif_done, verif_pareja;
    logic [15:0][4:0] arr_cards_in, arr_verif_in, arr_cards_out, exp_b, init_b, rst_b;
    logic [3:0] cursor;
    logic verif_start, turn_done, turn_match, board_complete, turn_timeout;
    int vectors = 0, miscompares = 0, vs_cnt = 0, td_cnt = 0, vs0, td0;

    seleccion_cartas #(.N_CARDS(16), .SHOW_CYCLES(SHOW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .load(load), .arr_cards_in(arr_cards_in), .turn_en(turn_en),
        .btn_next(btn_next), .btn_prev(btn_prev), .btn_sel(btn_sel),
        .verif_done(verif_done), .verif_pareja(verif_pareja), .arr_verif_in(arr_verif_in),
        .arr_cards_out(arr_cards_out), .cursor(cursor), .verif_start(verif_start),
        .turn_done(turn_done), .turn_match(turn_match), .board_complete(board_complete),
        .turn_timeout(turn_timeout)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (verif_start) vs_cnt++;
        if (turn_done)   td_cnt++;
    end

    task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic n, input logic p, input logic s);
        btn_next = n; btn_prev = p; btn_sel = s;
        tick();
        btn_next = 1'b0; btn_prev = 1'b0; btn_sel = 1'b0;
    endtask

    task automatic chk_state(input string tag, input logic [3:0] cur);
        chk({tag, "/board"}, arr_cards_out, exp_b);
        chk({tag, "/cursor"}, 80'(cursor), 80'(cur));
    endtask

    task automatic finish_verify(input logic pareja, input logic comp, input string tag);
        verif_pareja = pareja; verif_done = 1'b1;
        tick();
        verif_done = 1'b0;
        exp_b = arr_verif_in;
        chk({tag, "/board"}, arr_cards_out, exp_b);
        chk({tag, "/match"}, 80'(turn_match), 80'(pareja));
        chk({tag, "/done"}, 80'(turn_done), 80'(1));
        chk({tag, "/complete"}, 80'(board_complete), 80'(comp));
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; turn_en = 1'b0; btn_next = 1'b0; btn_prev = 1'b0; btn_sel = 1'b0;
        verif_done = 1'b0; verif_pareja = 1'b0; arr_cards_in = '0; arr_verif_in = '0;
        for (int i = 0; i < 16; i++) begin
            rst_b[i]  = 5'b00011;
            init_b[i] = {3'(i / 2), 2'b00};
        end
        exp_b = rst_b;
        repeat (2) @(posedge clk);
        #1;
        chk_state("reset", 4'd0);
        chk("reset/flags", 80'({verif_start, turn_done, turn_match, board_complete, turn_timeout}), 80'(0));
        rst = 1'b0;

        arr_cards_in = init_b; exp_b = init_b;
        load = 1'b1; tick(); load = 1'b0;
        chk_state("load", 4'd0);
        chk("load/flags", 80'({verif_start, turn_done, turn_match, board_complete}), 80'(0));
        press(1, 0, 0);
        chk_state("idle_btn", 4'd0);

        // Turn 1: cursor wrap, then pick cards 0 and 1, verifier reports a pair.
        turn_en = 1'b1; tick(); turn_en = 1'b0;
        press(0, 1, 0); chk("wrap_prev", 80'(cursor), 80'(15));
        press(1, 0, 0); chk("wrap_next", 80'(cursor), 80'(0));
        repeat (5) press(1, 0, 0);
        press(1, 1, 0); chk("both_btn", 80'(cursor), 80'(5));
        repeat (5) press(0, 1, 0);
        press(0, 0, 1); exp_b[0][1:0] = 2'b01; chk_state("t1_sel0", 4'd0);
        press(0, 0, 1); chk_state("t1_reselect", 4'd0);
        press(1, 0, 0);
        vs0 = vs_cnt; td0 = td_cnt;
        press(0, 0, 1); exp_b[1][1:0] = 2'b01; chk_state("t1_sel1", 4'd1);
        for (int k = 1; k <= SHOW; k++) begin
            tick();
            chk($sformatf("t1_start_%0d", k), 80'(verif_start), 80'(k == SHOW));
        end
        tick();
        chk("t1_start_off", 80'(verif_start), 80'(0));
        chk("t1_hold", arr_cards_out, exp_b);
        chk("t1_no_done", 80'(turn_done), 80'(0));
        arr_verif_in = exp_b; arr_verif_in[0][1:0] = 2'b10; arr_verif_in[1][1:0] = 2'b10;
        finish_verify(1'b1, 1'b0, "t1_end");
        tick();
        chk("t1_done_pulse", 80'(turn_done), 80'(0));
        chk("t1_start_count", 80'(vs_cnt - vs0), 80'(1));
        chk("t1_done_count", 80'(td_cnt - td0), 80'(1));

        // Turn 2: ignored selects on matched and already-open cards, then a non-match.
        turn_en = 1'b1; tick(); turn_en = 1'b0;
        press(0, 0, 1); chk_state("t2_sel_matched_p1", 4'd1);
        press(1, 0, 0); press(0, 0, 1); exp_b[2][1:0] = 2'b01; chk_state("t2_sel2", 4'd2);
        press(0, 1, 0); press(0, 0, 1); chk_state("t2_sel_matched_p2", 4'd1);
        press(1, 0, 0); press(0, 0, 1); chk_state("t2_reselect_pos1", 4'd2);
        vs0 = vs_cnt;
        repeat (6) tick();
        chk("t2_no_start", 80'(vs_cnt - vs0), 80'(0));
        press(1, 0, 0); press(1, 0, 0); press(0, 0, 1); exp_b[4][1:0] = 2'b01; chk_state("t2_sel4", 4'd4);
        repeat (SHOW) tick();
        chk("t2_start", 80'(verif_start), 80'(1));
        arr_verif_in = exp_b; arr_verif_in[2][1:0] = 2'b00; arr_verif_in[4][1:0] = 2'b00;
        finish_verify(1'b0, 1'b0, "t2_end");

        // Turn 3: last pair on a nearly complete board.
        for (int i = 0; i < 16; i++) arr_cards_in[i] = {3'(i / 2), (i < 14) ? 2'b10 : 2'b00};
        load = 1'b1; tick(); load = 1'b0;
        exp_b = arr_cards_in; chk_state("load2", 4'd0);
        turn_en = 1'b1; tick(); turn_en = 1'b0;
        press(0, 1, 0); press(0, 1, 0); press(0, 0, 1); exp_b[14][1:0] = 2'b01;
        press(1, 0, 0); press(0, 0, 1); exp_b[15][1:0] = 2'b01; chk_state("t3_sel15", 4'd15);
        repeat (SHOW) tick();
        chk("t3_start", 80'(verif_start), 80'(1));
        for (int i = 0; i < 16; i++) arr_verif_in[i] = {3'(i / 2), 2'b10};
        finish_verify(1'b1, 1'b1, "t3_end");

        // Complete board stays in IDLE until a load, which also wins over turn_en.
        vs0 = vs_cnt;
        turn_en = 1'b1;
        repeat (3) tick();
        press(1, 0, 0); press(0, 0, 1);
        chk_state("locked", 4'd15);
        chk("locked_no_start", 80'(vs_cnt - vs0), 80'(0));
        arr_cards_in = init_b;
        load = 1'b1; tick(); load = 1'b0;
        exp_b = init_b; chk_state("reload", 4'd0);
        chk("reload_complete", 80'(board_complete), 80'(0));
        tick(); turn_en = 1'b0;
        press(1, 0, 0); chk("reload_pick1", 80'(cursor), 80'(1));

        // Idle in PICK2: timeout build returns to IDLE after TO cycles, default build waits.
        press(1, 0, 0); press(1, 0, 0); press(0, 0, 1); exp_b[3][1:0] = 2'b01;
        vs0 = vs_cnt; td0 = td_cnt;
        for (int k = 1; k <= TO; k++) begin
            tick();
            chk($sformatf("to_pulse_%0d", k), 80'(turn_timeout), 80'(TO_EN && k == TO));
            chk($sformatf("to_done_%0d", k), 80'(turn_done), 80'(TO_EN && k == TO));
        end
        if (TO_EN) exp_b[3][1:0] = 2'b00;
        chk("to_board", arr_cards_out, exp_b);
        chk("to_match", 80'(turn_match), 80'(!TO_EN));
        repeat (12) tick();
        chk("to_no_start", 80'(vs_cnt - vs0), 80'(0));
        chk("to_done_count", 80'(td_cnt - td0), 80'(TO_EN));

        // Asynchronous reset mid-cycle.
        #2 rst = 1'b1;
        #1;
        exp_b = rst_b;
        chk_state("async_rst", 4'd0);
        chk("async_rst/flags", 80'({verif_start, turn_done, turn_match, board_complete, turn_timeout}), 80'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
